// File: rtl/serial_pair_serializer_msb_first_pkg.sv
// Shared types for the MSB-first serial comparator path: serializer FSM states
// and the default operand width.
package serial_cmp_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_t;

    localparam int SER_W_DEFAULT = 16;

endpackage

// File: rtl/serial_pair_serializer_msb_first_shift.sv
// Parallel-load, left-shifting register that presents its MSB as the serial bit.
// Zeros shift in from the bottom, so a fully streamed word leaves the register clear.
module msb_first_shift_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         out_bit
);

    logic [W-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= sr << 1;
        end
    end

    assign out_bit = sr[W-1];

endmodule

// File: rtl/serial_pair_serializer_msb_first.sv
// Streams an (a, b) operand pair MSB first, one bit per clock, with first/last
// frame markers so a downstream comparator can restart and sample per word.
module serial_pair_serializer_msb_first
    import serial_cmp_pkg::*;
#(
    parameter int W = SER_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_a,
    input  logic [W-1:0] up_b,
    output logic         ser_valid,
    output logic         ser_a,
    output logic         ser_b,
    output logic         ser_first,
    output logic         ser_last
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);

    ser_state_t    state;
    logic [CW-1:0] count;
    logic          first_q;
    logic          last_q;
    logic          load;
    logic          shift;

    // Ready again in the last-bit cycle lets the next word follow without a bubble.
    assign up_ready = (state == ST_IDLE) | last_q;
    assign load     = up_valid & up_ready;
    assign shift    = (state == ST_SHIFT) & ~load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            count   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (load) begin
            state   <= ST_SHIFT;
            count   <= CNT_MAX;
            first_q <= 1'b1;
            last_q  <= (W == 1);
        end else if (state == ST_SHIFT) begin
            first_q <= 1'b0;
            if (count == '0) begin
                state  <= ST_IDLE;
                last_q <= 1'b0;
            end else begin
                count  <= count - 1'b1;
                last_q <= (count == CW'(1));
            end
        end
    end

    msb_first_shift_reg #(.W(W)) u_shift_a (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .shift   (shift),
        .din     (up_a),
        .out_bit (ser_a)
    );

    msb_first_shift_reg #(.W(W)) u_shift_b (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .shift   (shift),
        .din     (up_b),
        .out_bit (ser_b)
    );

    assign ser_valid = (state == ST_SHIFT);
    assign ser_first = first_q;
    assign ser_last  = last_q;

endmodule

// File: tb/tb_serial_pair_serializer_msb_first.sv
// Scoreboard bench for the pair serializer: a W=16 and a W=1 instance run side by side.
module tb_serial_pair_serializer_msb_first;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        valid1 = 1'b0;
    logic [0:0]  a1 = '0;
    logic [0:0]  b1 = '0;

    logic ready16, sv16, sa16, sb16, sf16, sl16;
    logic ready1, sv1, sa1, sb1, sf1, sl1;

    int n_checks = 0;
    int n_fails  = 0;

    // Expected bits as {a, b, first, last}, pushed when the model sees a handshake.
    logic [3:0] q16[$];
    logic [3:0] q1[$];
    logic [4:0] s16, s1;
    logic       r16, r1;
    bit         hs16, hs1;

    always #5 clk = ~clk;

    serial_pair_serializer_msb_first #(.W(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .up_valid  (valid16),
        .up_ready  (ready16),
        .up_a      (a16),
        .up_b      (b16),
        .ser_valid (sv16),
        .ser_a     (sa16),
        .ser_b     (sb16),
        .ser_first (sf16),
        .ser_last  (sl16)
    );

    serial_pair_serializer_msb_first #(.W(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .up_valid  (valid1),
        .up_ready  (ready1),
        .up_a      (a1),
        .up_b      (b1),
        .ser_valid (sv1),
        .ser_a     (sa1),
        .ser_b     (sb1),
        .ser_first (sf1),
        .ser_last  (sl1)
    );

    // One clock: sample at negedge, score both DUTs, model handshakes, then step past posedge.
    task automatic tick();
        logic [3:0] e;
        logic       exp_r;
        @(negedge clk);
        s16 = {sv16, sa16, sb16, sf16, sl16};
        r16 = ready16;
        s1  = {sv1, sa1, sb1, sf1, sl1};
        r1  = ready1;

        n_checks++;
        if (q16.size() > 0) begin
            e = q16.pop_front();
            if (s16 !== {1'b1, e}) begin
                n_fails++;
                $display("[TB] FAIL sb16_bit: got {v,a,b,f,l}=%b expected %b", s16, {1'b1, e});
            end
        end else if (s16 !== 5'b0) begin
            n_fails++;
            $display("[TB] FAIL sb16_idle: got {v,a,b,f,l}=%b expected 00000", s16);
        end
        exp_r = (q16.size() == 0);
        n_checks++;
        if (r16 !== exp_r) begin
            n_fails++;
            $display("[TB] FAIL sb16_ready: got %b expected %b", r16, exp_r);
        end
        hs16 = 1'b0;
        if (rst) begin
            q16.delete();
        end else if (valid16 && exp_r) begin
            hs16 = 1'b1;
            for (int k = 15; k >= 0; k--)
                q16.push_back({a16[k], b16[k], k == 15, k == 0});
        end

        n_checks++;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            if (s1 !== {1'b1, e}) begin
                n_fails++;
                $display("[TB] FAIL sb1_bit: got {v,a,b,f,l}=%b expected %b", s1, {1'b1, e});
            end
        end else if (s1 !== 5'b0) begin
            n_fails++;
            $display("[TB] FAIL sb1_idle: got {v,a,b,f,l}=%b expected 00000", s1);
        end
        exp_r = (q1.size() == 0);
        n_checks++;
        if (r1 !== exp_r) begin
            n_fails++;
            $display("[TB] FAIL sb1_ready: got %b expected %b", r1, exp_r);
        end
        hs1 = 1'b0;
        if (rst) begin
            q1.delete();
        end else if (valid1 && exp_r) begin
            hs1 = 1'b1;
            q1.push_back({a1[0], b1[0], 1'b1, 1'b1});
        end

        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if ({r16, s16} !== 6'b100000) begin
            n_fails++;
            $display("[TB] FAIL reset16: got {ready,v,a,b,f,l}=%b expected 100000", {r16, s16});
        end
        n_checks++;
        if ({r1, s1} !== 6'b100000) begin
            n_fails++;
            $display("[TB] FAIL reset1: got {ready,v,a,b,f,l}=%b expected 100000", {r1, s1});
        end
    endtask

    task automatic test_single_word();
        logic [15:0] cap_a, cap_b;
        int          first_pos, last_pos;
        logic        gt, lt;
        cap_a = '0; cap_b = '0; first_pos = -1; last_pos = -1; gt = 0; lt = 0;
        a16 = 16'b0110_0100_1000_0010;
        b16 = 16'b0110_0010_0110_0010;
        valid16 = 1'b1;
        tick();
        valid16 = 1'b0;
        n_checks++;
        if (hs16 !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL single_hs: got %b expected 1", hs16);
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            cap_a[15-i] = s16[3];
            cap_b[15-i] = s16[2];
            if (s16[1]) begin
                first_pos = i; gt = 0; lt = 0;
            end
            if (s16[0]) last_pos = i;
            if (!gt && !lt) begin
                if (s16[3] && !s16[2]) gt = 1;
                else if (!s16[3] && s16[2]) lt = 1;
            end
        end
        n_checks++;
        if (cap_a !== 16'h6482 || cap_b !== 16'h6262) begin
            n_fails++;
            $display("[TB] FAIL single_word: got a=%h b=%h expected a=6482 b=6262", cap_a, cap_b);
        end
        n_checks++;
        if (first_pos != 0 || last_pos != 15) begin
            n_fails++;
            $display("[TB] FAIL single_markers: got first@%0d last@%0d expected first@0 last@15", first_pos, last_pos);
        end
        n_checks++;
        if (gt !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL single_cmp: got a_greater_b=%b expected 1", gt);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] pa [3];
        logic [15:0] pb [3];
        int idx, run, max_run, total_valid, hs_in_last;
        pa[0] = 16'hFFFF; pb[0] = 16'h0000;
        pa[1] = 16'h0000; pb[1] = 16'h0000;
        pa[2] = 16'h1234; pb[2] = 16'h1235;
        idx = 0; run = 0; max_run = 0; total_valid = 0; hs_in_last = 0;
        a16 = pa[0]; b16 = pb[0]; valid16 = 1'b1;
        for (int t = 0; t < 60; t++) begin
            tick();
            if (s16[4]) begin
                run++; total_valid++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (hs16) begin
                if (s16[0]) hs_in_last++;
                idx++;
                if (idx < 3) begin
                    a16 = pa[idx]; b16 = pb[idx];
                end else begin
                    valid16 = 1'b0;
                end
            end
        end
        valid16 = 1'b0;
        n_checks++;
        if (idx != 3) begin
            n_fails++;
            $display("[TB] FAIL b2b_handshakes: got %0d expected 3", idx);
        end
        n_checks++;
        if (total_valid != 48 || max_run != 48) begin
            n_fails++;
            $display("[TB] FAIL b2b_contiguous: got total=%0d run=%0d expected 48/48", total_valid, max_run);
        end
        n_checks++;
        if (hs_in_last != 2) begin
            n_fails++;
            $display("[TB] FAIL b2b_hs_in_last: got %0d expected 2", hs_in_last);
        end
    endtask

    task automatic test_hold_off();
        logic [15:0] cur, w0, w1;
        int nw, hs_tick, hs_cnt;
        cur = '0; w0 = '0; w1 = '0; nw = 0; hs_tick = -1; hs_cnt = 0;
        a16 = 16'hA5C3; b16 = 16'h0F0F; valid16 = 1'b1;
        tick();
        a16 = 16'h1111; b16 = 16'h2222;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (s16[4]) begin
                cur = {cur[14:0], s16[3]};
                if (s16[0]) begin
                    if (nw == 0) w0 = cur; else w1 = cur;
                    nw++;
                end
            end
            if (hs16) begin
                hs_cnt++; hs_tick = t; valid16 = 1'b0;
            end
        end
        n_checks++;
        if (nw != 2 || w0 !== 16'hA5C3 || w1 !== 16'h1111) begin
            n_fails++;
            $display("[TB] FAIL hold_words: got n=%0d w0=%h w1=%h expected 2 A5C3 1111", nw, w0, w1);
        end
        n_checks++;
        if (hs_cnt != 1 || hs_tick != 15) begin
            n_fails++;
            $display("[TB] FAIL hold_accept: got count=%0d at=%0d expected 1 at 15", hs_cnt, hs_tick);
        end
    endtask

    task automatic test_reset_mid_word();
        a16 = 16'hBEEF; b16 = 16'h1357; valid16 = 1'b1;
        tick();
        valid16 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        valid16 = 1'b1; a16 = 16'hC001; b16 = 16'h8002;
        tick();
        n_checks++;
        if (s16[4] !== 1'b1 || hs16) begin
            n_fails++;
            $display("[TB] FAIL rstmid_bit5: got valid=%b hs=%b expected valid=1 hs=0", s16[4], hs16);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (s16 !== 5'b0 || !hs16) begin
            n_fails++;
            $display("[TB] FAIL rstmid_idle: got {v,a,b,f,l}=%b hs=%b expected 00000 hs=1", s16, hs16);
        end
        valid16 = 1'b0;
        tick();
        n_checks++;
        if (s16 !== 5'b11110) begin
            n_fails++;
            $display("[TB] FAIL rstmid_restart: got {v,a,b,f,l}=%b expected 11110", s16);
        end
        for (int i = 0; i < 17; i++) tick();
    endtask

    task automatic test_w1();
        valid1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
        tick();
        n_checks++;
        if (!hs1 || r1 !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL w1_first_hs: got hs=%b ready=%b expected 1 1", hs1, r1);
        end
        a1 = 1'b0; b1 = 1'b1;
        tick();
        n_checks++;
        if (s1 !== 5'b11011 || r1 !== 1'b1 || !hs1) begin
            n_fails++;
            $display("[TB] FAIL w1_bit0: got {v,a,b,f,l}=%b ready=%b hs=%b expected 11011 1 1", s1, r1, hs1);
        end
        valid1 = 1'b0;
        tick();
        n_checks++;
        if (s1 !== 5'b10111 || r1 !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL w1_bit1: got {v,a,b,f,l}=%b ready=%b expected 10111 1", s1, r1);
        end
        tick();
        n_checks++;
        if (s1 !== 5'b00000 || r1 !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL w1_idle: got {v,a,b,f,l}=%b ready=%b expected 00000 1", s1, r1);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_hold_off();
        test_reset_mid_word();
        test_w1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
